// File: rtl/ones_count_accum_if.sv
// Handshake and result bundle between the ones-count stage, the frame accumulator and its consumer.
interface ones_count_accum_if;
    logic       in_valid;
    logic [3:0] count_in;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] frame_sum;
    logic [3:0] frame_max;
    logic       over_thresh;

    modport master (
        output in_valid, count_in, out_ready,
        input  in_ready, out_valid, frame_sum, frame_max, over_thresh
    );

    modport slave (
        input  in_valid, count_in, out_ready,
        output in_ready, out_valid, frame_sum, frame_max, over_thresh
    );
endinterface

// File: rtl/ones_count_accum.sv
// Accumulates FRAME_LEN ones-count samples into a frame sum and maximum, then holds the
// result until the consumer takes it.
module ones_count_accum #(
    parameter int unsigned FRAME_LEN = 8,
    parameter logic [7:0]  THRESH    = 8'd60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    ones_count_accum_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [4:0] LEN = 5'(FRAME_LEN);

    state_t     state;
    logic [7:0] acc;
    logic [3:0] max_r;
    logic [4:0] sample_cnt;
    logic       out_valid_r;
    logic [7:0] frame_sum_r;
    logic [3:0] frame_max_r;
    logic       over_thresh_r;

    logic       accept;
    logic [7:0] sum_nxt;
    logic [3:0] max_nxt;
    logic [4:0] cnt_nxt;
    logic       last;

    // The IDLE load is folded into the running update so both states share one adder.
    always_comb begin
        accept  = bus.in_valid && (state != HOLD);
        sum_nxt = (state == IDLE) ? {4'b0000, bus.count_in} : acc + {4'b0000, bus.count_in};
        max_nxt = ((state == IDLE) || (bus.count_in > max_r)) ? bus.count_in : max_r;
        cnt_nxt = (state == IDLE) ? 5'd1 : sample_cnt + 5'd1;
        last    = (cnt_nxt == LEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            max_r         <= '0;
            sample_cnt    <= '0;
            out_valid_r   <= 1'b0;
            frame_sum_r   <= '0;
            frame_max_r   <= '0;
            over_thresh_r <= 1'b0;
        end else if (clear) begin
            state         <= IDLE;
            acc           <= '0;
            max_r         <= '0;
            sample_cnt    <= '0;
            out_valid_r   <= 1'b0;
            frame_sum_r   <= '0;
            frame_max_r   <= '0;
            over_thresh_r <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc        <= sum_nxt;
                        max_r      <= max_nxt;
                        sample_cnt <= cnt_nxt;
                        if (last) begin
                            state         <= HOLD;
                            out_valid_r   <= 1'b1;
                            frame_sum_r   <= sum_nxt;
                            frame_max_r   <= max_nxt;
                            over_thresh_r <= (sum_nxt >= THRESH);
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        acc         <= '0;
                        max_r       <= '0;
                        sample_cnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state != HOLD);
    assign bus.out_valid   = out_valid_r;
    assign bus.frame_sum   = frame_sum_r;
    assign bus.frame_max   = frame_max_r;
    assign bus.over_thresh = over_thresh_r;

endmodule

// File: tb/tb_ones_count_accum.sv
// Bench for ones_count_accum: frame results are queued when a frame is driven and popped at the output handshake.
module tb_ones_count_accum;

    typedef struct packed {
        logic [7:0] sum;
        logic [3:0] mx;
        logic       ov;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clear;
    int   checks;
    int   errors;
    int   acc_count;
    exp_t sb[$];

    ones_count_accum_if bus ();
    ones_count_accum_if bus1 ();

    ones_count_accum #(.FRAME_LEN(8), .THRESH(8'd60)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus.slave)
    );

    ones_count_accum #(.FRAME_LEN(1), .THRESH(8'd15)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output-side scoreboard: a handshake is visible mid-cycle and completes on the next edge.
    always @(negedge clk) begin
        if (rst_n && !clear && bus.in_valid && bus.in_ready)
            acc_count++;
        if (rst_n && !clear && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got sum=%0d max=%0d over=%0b with empty scoreboard",
                         bus.frame_sum, bus.frame_max, bus.over_thresh);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.frame_sum, bus.frame_max, bus.over_thresh} !== e) begin
                    errors++;
                    $display("FAIL frame_result got sum=%0d max=%0d over=%0b want sum=%0d max=%0d over=%0b",
                             bus.frame_sum, bus.frame_max, bus.over_thresh, e.sum, e.mx, e.ov);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [3:0] v);
        logic rdy;
        int   n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.count_in = v;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #2;
            n++;
        end while (!rdy && n < 50);
        bus.in_valid = 1'b0;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_accept got in_ready=0 for %0d cycles want 1", n);
        end
    endtask

    task automatic wait_out(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        @(posedge clk);
        #2;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout got out_valid=0 want 1 within 20 cycles", name);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({bus.out_valid, bus.frame_sum, bus.frame_max, bus.over_thresh, bus.in_ready} !== {1'b0, 8'd0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL %s got ov=%0b sum=%0d max=%0d over=%0b rdy=%0b want 0 0 0 0 1", name,
                     bus.out_valid, bus.frame_sum, bus.frame_max, bus.over_thresh, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.count_in = '0;
        bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.count_in = '0;
        bus1.out_ready = 1'b0;
        #1;
        check_zero("reset_state");
        @(posedge clk);
        #2;
        check_zero("reset_held");
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        sb.push_back('{sum: 8'd36, mx: 4'd8, ov: 1'b0});
        for (int i = 1; i <= 8; i++) send(4'(i));
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_latency got out_valid=%0b want 1", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_one_cycle got out_valid=%0b in_ready=%0b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0;
        sb.push_back('{sum: 8'd120, mx: 4'd15, ov: 1'b1});
        for (int i = 0; i < 8; i++) send(4'd15);
        bus.in_valid = 1'b1;
        bus.count_in = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.frame_sum, bus.frame_max, bus.over_thresh} !== {1'b1, 1'b0, 8'd120, 4'd15, 1'b1}) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got ov=%0b rdy=%0b sum=%0d max=%0d over=%0b want 1 0 120 15 1",
                         i, bus.out_valid, bus.in_ready, bus.frame_sum, bus.frame_max, bus.over_thresh);
            end
        end
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_exit got out_valid=%0b in_ready=%0b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_gapped();
        logic [3:0] smp [8];
        int         start;
        smp = '{4'd7, 4'd0, 4'd0, 4'd9, 4'd3, 4'd3, 4'd3, 4'd15};
        bus.out_ready = 1'b1;
        start = acc_count;
        sb.push_back('{sum: 8'd40, mx: 4'd15, ov: 1'b0});
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) begin
                bus.count_in = 4'($urandom);
                @(posedge clk);
                #2;
            end
            send(smp[i]);
        end
        wait_out("gapped");
        checks++;
        if (acc_count - start !== 8) begin
            errors++;
            $display("FAIL gapped_accepts got %0d want 8", acc_count - start);
        end
    endtask

    task automatic test_thresh_boundary();
        bus.out_ready = 1'b1;
        sb.push_back('{sum: 8'd60, mx: 4'd15, ov: 1'b1});
        for (int i = 0; i < 4; i++) send(4'd15);
        for (int i = 0; i < 4; i++) send(4'd0);
        wait_out("thresh_eq");
        sb.push_back('{sum: 8'd59, mx: 4'd15, ov: 1'b0});
        for (int i = 0; i < 3; i++) send(4'd15);
        send(4'd14);
        for (int i = 0; i < 4; i++) send(4'd0);
        wait_out("thresh_below");
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(4'd4);
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_frame");
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(4'd9);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.frame_sum, bus.frame_max, bus.over_thresh} !== {1'b1, 8'd72, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL reset_frame_hold got ov=%0b sum=%0d max=%0d over=%0b want 1 72 9 1",
                     bus.out_valid, bus.frame_sum, bus.frame_max, bus.over_thresh);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_in_hold");
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        sb.push_back('{sum: 8'd52, mx: 4'd10, ov: 1'b0});
        for (int i = 10; i >= 3; i--) send(4'(i));
        wait_out("after_reset");
    endtask

    task automatic test_clear();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(4'd5);
        bus.in_valid = 1'b1;
        bus.count_in = 4'd5;
        clear = 1'b1;
        @(posedge clk);
        #2;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL clear_abort got out_valid=%0b in_ready=%0b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #2;
        sb.push_back('{sum: 8'd8, mx: 4'd1, ov: 1'b0});
        for (int i = 0; i < 8; i++) send(4'd1);
        wait_out("clear_next");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(4'd2);
        clear = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #2;
        clear = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL clear_in_hold got out_valid=%0b in_ready=%0b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_single_sample();
        logic [3:0] v [2];
        v = '{4'd15, 4'd14};
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus1.in_valid = 1'b1;
            bus1.count_in = v[i];
            @(posedge clk);
            #2;
            bus1.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus1.out_valid, bus1.frame_sum, bus1.frame_max, bus1.over_thresh} !== {1'b1, 4'd0, v[i], v[i], (i == 0)}) begin
                errors++;
                $display("FAIL len1_result got ov=%0b sum=%0d max=%0d over=%0b want 1 %0d %0d %0b",
                         bus1.out_valid, bus1.frame_sum, bus1.frame_max, bus1.over_thresh, v[i], v[i], (i == 0));
            end
            @(posedge clk);
            #2;
            checks++;
            if ({bus1.out_valid, bus1.in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL len1_release got out_valid=%0b in_ready=%0b want 0 1", bus1.out_valid, bus1.in_ready);
            end
        end
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        acc_count = 0;
        test_reset();
        test_back_to_back();
        test_hold();
        test_gapped();
        test_thresh_boundary();
        test_async_reset();
        test_clear();
        test_single_sample();
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending results want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
